// File: rtl/som_if_ram_loader_if.sv
// Upstream pixel stream plus RAM_IF write port of the SOM input-feature loader.
// The loader connects through the slave modport; the stream source / RAM model uses master.
interface som_if_ram_loader_if #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 18
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              in_ready;
    logic [ADDR_W-1:0] RAM_IF_A;
    logic [DATA_W-1:0] RAM_IF_D;
    logic              RAM_IF_WE;

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, RAM_IF_A, RAM_IF_D, RAM_IF_WE
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, RAM_IF_A, RAM_IF_D, RAM_IF_WE
    );
endinterface

// File: rtl/som_if_ram_loader.sv
// Loads one DEPTH-word frame from a valid/ready stream into RAM_IF and pulses load_done.
// Optional frame checksum enabled by the SOM_IF_CKSUM_EN macro.
module som_if_ram_loader #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 18,
    parameter int DEPTH  = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    som_if_ram_loader_if.slave  bus,
    output logic                busy,
    output logic                load_done,
    output logic                frame_err,
    output logic [15:0]         checksum
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic              accept;

    assign accept = bus.in_valid && (state_q == LOAD);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = 1'b0;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            LOAD: begin
                if (accept) begin
                    addr_d = cnt_q[ADDR_W-1:0];
                    data_d = bus.in_data;
                    we_d   = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    // Leaving at DEPTH-1 is what keeps cnt from ever addressing past the frame.
                    if (cnt_q == LAST_CNT) begin
                        state_d = DONE;
                        err_d   = !bus.in_last;
                    end else if (bus.in_last) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end

`ifdef SOM_IF_CKSUM_EN
    logic [15:0] ck_q, ck_d;
    logic [15:0] data16;

    if (DATA_W >= 16) begin : g_data_wide
        assign data16 = bus.in_data[15:0];
    end else begin : g_data_narrow
        assign data16 = {{(16-DATA_W){1'b0}}, bus.in_data};
    end

    always_comb begin
        ck_d = ck_q;
        if (state_q == IDLE && start) begin
            ck_d = '0;
        end else if (accept) begin
            ck_d = ck_q + data16;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ck_q <= '0;
        end else begin
            ck_q <= ck_d;
        end
    end

    assign checksum = ck_q;
`else
    assign checksum = 16'h0000;
`endif

    // All status outputs decode straight from flops, so reset clears them at once.
    assign bus.in_ready  = (state_q == LOAD);
    assign bus.RAM_IF_A  = addr_q;
    assign bus.RAM_IF_D  = data_q;
    assign bus.RAM_IF_WE = we_q;
    assign busy          = (state_q != IDLE);
    assign load_done     = (state_q == DONE);
    assign frame_err     = err_q;

endmodule

// File: tb/tb_som_if_ram_loader.sv
// Scoreboard bench for som_if_ram_loader: driver pushes expected writes/completions, monitor pops on RAM_IF_WE / load_done.
module tb_som_if_ram_loader;
    localparam int DATA_W = 24;
    localparam int ADDR_W = 18;
    localparam int DEPTH  = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        load_done;
    logic        frame_err;
    logic [15:0] checksum;

    som_if_ram_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    som_if_ram_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bus       (bus),
        .busy      (busy),
        .load_done (load_done),
        .frame_err (frame_err),
        .checksum  (checksum)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    typedef struct packed {
        logic              err;
        logic [ADDR_W-1:0] a;
        logic [15:0]       ck;
    } done_t;

    wr_t   wq[$];
    done_t dq[$];
    wr_t   mon_w;
    done_t mon_d;

    int          checks   = 0;
    int          failures = 0;
    int          exp_cnt  = 0;
    logic        exp_load = 1'b0;
    logic [15:0] exp_ck   = 16'h0000;
    logic [15:0] ck_final;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_event(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=event required=none", name);
    endtask

    // Monitor: every write and every completion must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.RAM_IF_WE) begin
                if (wq.size() == 0) begin
                    fail_event("unexpected_write");
                end else begin
                    mon_w = wq.pop_front();
                    check("wr_addr", 64'(bus.RAM_IF_A), 64'(mon_w.a));
                    check("wr_data", 64'(bus.RAM_IF_D), 64'(mon_w.d));
                end
            end
            if (load_done) begin
                if (dq.size() == 0) begin
                    fail_event("unexpected_load_done");
                end else begin
                    mon_d = dq.pop_front();
                    check("done_frame_err", 64'(frame_err), 64'(mon_d.err));
                    check("done_addr", 64'(bus.RAM_IF_A), 64'(mon_d.a));
                    check("done_with_we", 64'(bus.RAM_IF_WE), 64'd1);
                    check("done_checksum", 64'(checksum), 64'(mon_d.ck));
                end
            end
        end
    end

    // One driver cycle; inputs change 1 time unit after the rising edge.
    task automatic cyc(input logic v, input logic [DATA_W-1:0] d, input logic l);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_last  = l;
        check("in_ready", 64'(bus.in_ready), 64'(exp_load));
        if (v && exp_load) begin
            wq.push_back('{a: exp_cnt[ADDR_W-1:0], d: d});
`ifdef SOM_IF_CKSUM_EN
            exp_ck = exp_ck + d[15:0];
`endif
            if (exp_cnt == DEPTH - 1) begin
                dq.push_back('{err: !l, a: exp_cnt[ADDR_W-1:0], ck: exp_ck});
                exp_load = 1'b0;
            end else if (l) begin
                dq.push_back('{err: 1'b1, a: exp_cnt[ADDR_W-1:0], ck: exp_ck});
                exp_load = 1'b0;
            end
            exp_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, '0, 1'b0);
    endtask

    task automatic do_start();
        bus.in_valid = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        exp_load = 1'b1;
        exp_cnt  = 0;
        exp_ck   = 16'h0000;
        check("busy_after_start", 64'(busy), 64'd1);
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        #1;
        check("rst_we", 64'(bus.RAM_IF_WE), 64'd0);
        check("rst_a", 64'(bus.RAM_IF_A), 64'd0);
        check("rst_d", 64'(bus.RAM_IF_D), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_load_done", 64'(load_done), 64'd0);
        check("rst_frame_err", 64'(frame_err), 64'd0);
        check("rst_checksum", 64'(checksum), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        idle(2);

        // Full frame, data = address, last on word 4095.
        do_start();
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, DATA_W'(i), i == DEPTH - 1);
        idle(3);
        check("full_frame_err", 64'(frame_err), 64'd0);
        check("full_busy_after", 64'(busy), 64'd0);
        check("full_drained", 64'(wq.size() + dq.size()), 64'd0);

        // Upstream gaps: valid pattern 1,0,0,1.
        do_start();
        for (int n = 0; n < 20000 && exp_load; n++) begin
            logic v;
            v = (n % 4 == 0) || (n % 4 == 3);
            cyc(v, DATA_W'(32'hA00000 + n), v && (exp_cnt == DEPTH - 1));
        end
        check("gap_frame_finished", 64'(exp_load), 64'd0);
        idle(3);
        check("gap_frame_err", 64'(frame_err), 64'd0);

        // Short frame: last on word 9.
        do_start();
        for (int i = 0; i < 10; i++) cyc(1'b1, DATA_W'(32'h5A0000 + i), i == 9);
        idle(3);
        check("short_err_sticky", 64'(frame_err), 64'd1);

        // Missing last: the start that begins it must clear frame_err.
        do_start();
        check("start_clears_err", 64'(frame_err), 64'd0);
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, ~DATA_W'(i), 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, DATA_W'(32'hBAD000 + i), 1'b1);
        bus.in_valid = 1'b0;
        check("missing_err", 64'(frame_err), 64'd1);
        check("missing_busy", 64'(busy), 64'd0);

        // start pulsed at cnt=100 while loading is ignored.
        do_start();
        for (int i = 0; i < DEPTH; i++) begin
            start = (i == 100);
            cyc(1'b1, DATA_W'(i * 3), i == DEPTH - 1);
        end
        start = 1'b0;
        idle(3);
        check("restart_ignored_err", 64'(frame_err), 64'd0);

        // Asynchronous reset in the middle of a cycle at cnt=2000.
        do_start();
        for (int i = 0; i <= 2000; i++) cyc(1'b1, DATA_W'(32'h300000 + i), 1'b0);
        check("pre_rst_we", 64'(bus.RAM_IF_WE), 64'd1);
        check("pre_rst_busy", 64'(busy), 64'd1);
        bus.in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_we", 64'(bus.RAM_IF_WE), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("mid_rst_addr", 64'(bus.RAM_IF_A), 64'd0);
        wq.delete();
        dq.delete();
        exp_load = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Fresh frame after reset starts at A=0; short 4-word checksum frame.
        do_start();
        cyc(1'b1, 24'h00FFFF, 1'b0);
        cyc(1'b1, 24'h000002, 1'b0);
        cyc(1'b1, 24'h000010, 1'b0);
        cyc(1'b1, 24'h000100, 1'b1);
        idle(3);
`ifdef SOM_IF_CKSUM_EN
        ck_final = 16'h0111;
`else
        ck_final = 16'h0000;
`endif
        check("cksum_final", 64'(checksum), 64'(ck_final));
        check("cksum_frame_err", 64'(frame_err), 64'd1);
        check("final_drained", 64'(wq.size() + dq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
